// File: rtl/cpu_types_pkg.sv
// Shared CPU types: opcodes, register fields, instruction field helpers and hazard FSM states.
package cpu_types_pkg;

  localparam int unsigned WORD_W   = 32;
  localparam int unsigned OPCODE_W = 6;
  localparam int unsigned REG_W    = 5;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [REG_W-1:0]  regbits_t;

  typedef enum logic [OPCODE_W-1:0] {
    RTYPE = 6'h00,
    BEQ   = 6'h04,
    BNE   = 6'h05,
    LW    = 6'h23,
    SW    = 6'h2b,
    HALT  = 6'h3f
  } opcode_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DWAIT  = 2'd1,
    HALTED = 2'd2
  } hazard_state_t;

  function automatic logic [OPCODE_W-1:0] get_op(input word_t instr);
    return instr[31:26];
  endfunction

  function automatic regbits_t get_rs(input word_t instr);
    return instr[25:21];
  endfunction

  function automatic regbits_t get_rt(input word_t instr);
    return instr[20:16];
  endfunction

endpackage

// File: rtl/hazard_unit_if.vh
// Bundle between the hazard unit and the datapath latches.
`ifndef HAZARD_UNIT_IF_VH
`define HAZARD_UNIT_IF_VH

interface hazard_unit_if #(parameter int unsigned STALL_CNT_W = 16);
  logic                   ihit, dhit;
  logic [31:0]            ifid_instr, idex_instr;
  logic                   idex_dren, exmem_dren, exmem_dwen;
  logic                   exmem_pcsrc, memwb_halt;
  logic                   pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic                   ifid_flush, idex_flush, exmem_flush;
  logic                   halt;
  logic [STALL_CNT_W-1:0] stall_cnt;

  modport hu (
    input  ihit, dhit, ifid_instr, idex_instr, idex_dren, exmem_dren, exmem_dwen,
           exmem_pcsrc, memwb_halt,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, halt, stall_cnt
  );

  modport dp (
    output ihit, dhit, ifid_instr, idex_instr, idex_dren, exmem_dren, exmem_dwen,
           exmem_pcsrc, memwb_halt,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, halt, stall_cnt
  );
endinterface

`endif

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: load-use, data/instruction memory waits, branch squash and halt.
module hazard_unit
  import cpu_types_pkg::*;
#(
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   ihit,
  input  logic                   dhit,
  input  logic [31:0]            ifid_instr,
  input  logic [31:0]            idex_instr,
  input  logic                   idex_dren,
  input  logic                   exmem_dren,
  input  logic                   exmem_dwen,
  input  logic                   exmem_pcsrc,
  input  logic                   memwb_halt,
  output logic                   pc_en,
  output logic                   ifid_en,
  output logic                   idex_en,
  output logic                   exmem_en,
  output logic                   memwb_en,
  output logic                   ifid_flush,
  output logic                   idex_flush,
  output logic                   exmem_flush,
  output logic                   halt,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  hazard_state_t         state;
  logic                  dmiss;
  logic                  load_use;
  logic [OPCODE_W-1:0]   ifid_op;
  regbits_t              ifid_rs, ifid_rt, idex_rt;
  logic                  unused_bits;

  // Load in ID/EX writes rt; stall if the IF/ID instruction sources that register.
  function automatic logic load_use_hit(input logic ld, input regbits_t ld_rt,
                                        input logic [OPCODE_W-1:0] op,
                                        input regbits_t rs, input regbits_t rt);
    logic rt_is_src;
    rt_is_src = (op == RTYPE) || (op == BEQ) || (op == BNE) || (op == SW);
    return ld && (ld_rt != '0) && ((ld_rt == rs) || (rt_is_src && (ld_rt == rt)));
  endfunction

  assign ifid_op     = get_op(ifid_instr);
  assign ifid_rs     = get_rs(ifid_instr);
  assign ifid_rt     = get_rt(ifid_instr);
  assign idex_rt     = get_rt(idex_instr);
  assign unused_bits = ^{ifid_instr[15:0], idex_instr[31:21], idex_instr[15:0]};

  assign dmiss    = (exmem_dren | exmem_dwen) & ~dhit;
  assign load_use = load_use_hit(idex_dren, idex_rt, ifid_op, ifid_rs, ifid_rt);

  // Latch controls, highest priority first.
  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    exmem_en    = 1'b1;
    memwb_en    = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    if (RST) begin
      pc_en = 1'b1;
    end else if (state == HALTED || dmiss) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
      memwb_en = 1'b0;
    end else if (exmem_pcsrc) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
    end else if (load_use) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
    end else if (!ihit) begin
      pc_en      = 1'b0;
      ifid_flush = 1'b1;
    end
  end

  // State, sticky halt and saturating stall counter.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= RUN;
      halt      <= 1'b0;
      stall_cnt <= '0;
    end else begin
      if (memwb_halt || state == HALTED) begin
        state <= HALTED;
        halt  <= 1'b1;
      end else begin
        case (state)
          RUN:     if (dmiss) state <= DWAIT;
          DWAIT:   if (dhit)  state <= RUN;
          default: state <= RUN;
        endcase
      end
      if (!pc_en && state != HALTED && stall_cnt != '1)
        stall_cnt <= stall_cnt + STALL_CNT_W'(1);
    end
  end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard controller for the five-stage MIPS datapath. It sits beside the operand-forwarding logic and covers the hazards forwarding cannot resolve: load-use, cache misses, taken branches/jumps, and halt. It produces per-latch enable and flush controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB. It also holds a sticky halt state and a saturating stall counter.

## Interface
- STALL_CNT_W, 16, width of the stall-cycle counter
- CLK  in  1  pipeline clock, rising edge
- RST  in  1  asynchronous, active-high reset
- ihit  in  1  instruction fetch complete this cycle
- dhit  in  1  data access complete this cycle
- ifid_instr  in  32  instruction held in IF/ID
- idex_instr  in  32  instruction held in ID/EX
- idex_dren  in  1  ID/EX instruction is a load
- exmem_dren, exmem_dwen  in  1 each  EX/MEM instruction reads / writes data memory
- exmem_pcsrc  in  1  branch taken or jump resolved in EX/MEM
- memwb_halt  in  1  HALT opcode present in MEM/WB
- pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  latch enables
- ifid_flush, idex_flush, exmem_flush  out  1 each  load a bubble (all-zero NOP) on the next edge
- halt  out  1  sticky halt to the system
- stall_cnt  out  STALL_CNT_W  saturating count of cycles with pc_en low

## Operation
- FSM states: RUN, DWAIT, HALTED. Enables and flushes are combinational from the state and inputs.
- HALTED is entered from any state when memwb_halt=1 on a clock edge. Halt has the highest priority after reset.
  - In HALTED, all enables are 0, all flushes are 0, and halt=1.
  - The state is left only on RST.
- The data-miss condition is dmiss = (exmem_dren|exmem_dwen) & ~dhit.
  - RUN with dmiss goes to DWAIT. While dmiss is true, all five enables are 0.
  - DWAIT with dhit returns to RUN. In that cycle all enables are 1 and the normal rules below apply.
- Branch flush applies when exmem_pcsrc=1 and dmiss=0. It sets ifid_flush, idex_flush and exmem_flush to 1.
  - All enables stay 1, so pc_en loads the branch target.
  - Branch flush overrides load-use and imem wait.
- Load-use stall:
  - Condition: idex_dren=1, rt(idex)≠0, and either
    - rt(idex)=rs(ifid), or
    - rt(ifid) is a source and rt(idex)=rt(ifid). rt(ifid) counts as a source for R-type, BEQ, BNE and SW.
  - Action: pc_en=0, ifid_en=0, idex_flush=1. EX/MEM and MEM/WB advance.
  - Exactly one bubble is inserted. The next cycle the load is in EX/MEM, where forwarding supplies the data.
- Imem wait: ihit=0 with no higher-priority condition gives pc_en=0, ifid_flush=1. Downstream stages advance.
- Priority: RST > HALTED > dmiss > branch flush > load-use > imem wait > normal.
  - Normal means all enables 1 and all flushes 0.
- Flush and enable of the same latch may both be 1. Flush wins and the latch loads the NOP.
- stall_cnt increments by 1 on each edge where pc_en=0 and the state is not HALTED. It saturates at all-ones; there is no wrap.

## Timing
- Reset values: state=RUN, halt=0, stall_cnt=0.
  - Outputs during reset: all enables 1, all flushes 0.
- Zero-cycle decision latency: controls are valid in the same cycle as their inputs.
- State and stall_cnt update on the rising CLK edge.
- halt goes to 1 the cycle after the edge that samples memwb_halt=1.
- Load-use costs 1 cycle. A taken branch costs 3 squashed slots. A dmiss costs N cycles, where N is the number of cycles before dhit.
- Reset asserted mid-stall returns to RUN immediately and asynchronously; no pending stall is retained.

## Structure
- Use cpu_types_pkg for the following; do not redefine them locally:
  - opcode_t values LW, SW, BEQ, BNE, RTYPE, HALT
  - regbits_t
  - field-slice helpers for rs/rt
- Add hazard_state_t (RUN, DWAIT, HALTED) to cpu_types_pkg.
- Interface file: hazard_unit_if.vh, with a modport for the unit and one for the datapath.
- No sub-module. The load-use comparator is a local function.

## Test plan
- LW $2 in ID/EX, ADD $3,$2,$4 in IF/ID, ihit=dhit=1 -> one cycle with pc_en=0, ifid_en=0, idex_flush=1; the next cycle is normal; stall_cnt=1.
- LW $0 in ID/EX, consumer reads $0 -> no stall, all enables 1.
- Store in EX/MEM with dhit low for 3 cycles -> all enables 0 for 3 cycles; state DWAIT; RUN when dhit=1; stall_cnt=3.
- exmem_pcsrc=1 while ihit=0 and a load-use condition is also present -> ifid/idex/exmem flush=1, pc_en=1.
- memwb_halt=1 -> halt=1 on the next cycle, enables 0 and held; RST pulse -> RUN, halt=0, stall_cnt=0.
- Force 2^16+5 imem-wait cycles -> stall_cnt holds 16'hFFFF.
